byte_packer: RTL and testbench

- Upstream feeder for the 32-bit load register. It collects a stream of bytes over a valid/ready handshake and packs them into one word.
- When the word is complete, or when a flush forces it out, it presents the word on d and asserts load for one accepted cycle.
- Sits between a byte-wide source (e.g. switch/serial front end) and the register's d/load inputs.

---
 rtl/byte_packer_pkg.sv | 20 ++
 rtl/byte_packer.sv | 81 ++++++++
 tb/tb_byte_packer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_packer_pkg.sv
// Shared types and helpers for the byte packer.
package byte_packer_pkg;

    localparam int DEF_BYTE_W = 8;
    localparam int DEF_BYTES_PER_WORD = 4;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int lane_idx(
        input int k,
        input int n,
        input logic big
    );
        return big ? (n - 1 - k) : k;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream into words for the load register.
// BYTE_PACKER_BIG_ENDIAN_EN places the first byte in the MSBs.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    localparam int WORD_W = BYTE_W * BYTES_PER_WORD,
    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              load,
    output logic [WORD_W-1:0] d,
    output logic [CNT_W-1:0]  byte_cnt
);

`ifdef BYTE_PACKER_BIG_ENDIAN_EN
    localparam logic BIG = 1'b1;
`else
    localparam logic BIG = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);

    state_t            state, state_n;
    logic [WORD_W-1:0] d_n;
    logic [CNT_W-1:0]  cnt_n;
    int                lane;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FILL;
            d        <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_n;
            d        <= d_n;
            byte_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        d_n      = d;
        cnt_n    = byte_cnt;
        load     = 1'b0;
        in_ready = 1'b0;
        lane     = lane_idx(32'(byte_cnt), BYTES_PER_WORD, BIG);
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    d_n[lane*BYTE_W +: BYTE_W] = in_byte;
                    cnt_n = byte_cnt + CNT_W'(1);
                end
                // A same-cycle byte is stored before a flush emits the word.
                if (in_valid && byte_cnt == LAST) begin
                    state_n = EMIT;
                end else if (flush && (in_valid || byte_cnt != '0)) begin
                    state_n = EMIT;
                end
            end
            EMIT: begin
                load = out_ready;
                if (out_ready) begin
                    state_n = FILL;
                    d_n     = '0;
                    cnt_n   = '0;
                end
            end
            default: state_n = FILL;
        endcase
    end

endmodule

// File: tb/tb_byte_packer.sv
// Directed self-checking bench for byte_packer.
// Expected words follow BYTE_PACKER_BIG_ENDIAN_EN when defined.
module tb_byte_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        load;
    logic [31:0] d;
    logic [2:0]  byte_cnt;

    int vec;
    int errs;

`ifdef BYTE_PACKER_BIG_ENDIAN_EN
    localparam logic [31:0] W_FULL = 32'h11223344;
    localparam logic [31:0] W_AB   = 32'hAABB0000;
    localparam logic [31:0] W_CC   = 32'hCC000000;
    localparam logic [31:0] W_P3   = 32'h11223300;
    localparam logic [31:0] W_A    = 32'hAA000000;
`else
    localparam logic [31:0] W_FULL = 32'h44332211;
    localparam logic [31:0] W_AB   = 32'h0000BBAA;
    localparam logic [31:0] W_CC   = 32'h000000CC;
    localparam logic [31:0] W_P3   = 32'h00332211;
    localparam logic [31:0] W_A    = 32'h000000AA;
`endif

    byte_packer dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .in_ready(in_ready),
        .flush(flush),
        .out_ready(out_ready),
        .load(load),
        .d(d),
        .byte_cnt(byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        in_valid = 1'b1;
        in_byte  = b;
        flush    = f;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
    endtask

    task automatic send4();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_byte = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        #12;
        vec++;
        if (d !== 32'h0 || byte_cnt !== 3'd0 || load !== 1'b0) begin
            $display("FAIL reset_state d=%h cnt=%0d load=%b exp 0/0/0",
                     d, byte_cnt, load);
            errs++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
            errs++;
        end
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        send4();
        vec++;
        if (load !== 1'b1 || d !== W_FULL || byte_cnt !== 3'd4) begin
            $display("FAIL full_emit load=%b d=%h cnt=%0d exp 1 %h 4",
                     load, d, byte_cnt, W_FULL);
            errs++;
        end
        vec++;
        if (in_ready !== 1'b0) begin
            $display("FAIL full_in_ready got %b exp 0", in_ready);
            errs++;
        end
        tick();
        vec++;
        if (load !== 1'b0 || d !== 32'h0 || byte_cnt !== 3'd0) begin
            $display("FAIL full_after load=%b d=%h cnt=%0d exp 0 0 0",
                     load, d, byte_cnt);
            errs++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send4();
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (load !== 1'b0 || in_ready !== 1'b0 || d !== W_FULL) begin
                $display("FAIL hold_%0d load=%b rdy=%b d=%h exp 0 0 %h",
                         i, load, in_ready, d, W_FULL);
                errs++;
            end
            flush = 1'b1;
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        vec++;
        if (load !== 1'b1 || d !== W_FULL) begin
            $display("FAIL release_load load=%b d=%h exp 1 %h",
                     load, d, W_FULL);
            errs++;
        end
        tick();
        vec++;
        if (load !== 1'b0 || byte_cnt !== 3'd0) begin
            $display("FAIL single_pulse load=%b cnt=%0d exp 0 0",
                     load, byte_cnt);
            errs++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        vec++;
        if (load !== 1'b0 || byte_cnt !== 3'd2) begin
            $display("FAIL partial load=%b cnt=%0d exp 0 2", load, byte_cnt);
            errs++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vec++;
        if (load !== 1'b1 || d !== W_AB) begin
            $display("FAIL flush_word load=%b d=%h exp 1 %h", load, d, W_AB);
            errs++;
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vec++;
        if (load !== 1'b0 || byte_cnt !== 3'd0 || in_ready !== 1'b1) begin
            $display("FAIL empty_flush load=%b cnt=%0d rdy=%b exp 0 0 1",
                     load, byte_cnt, in_ready);
            errs++;
        end
    endtask

    task automatic test_flush_with_byte();
        out_ready = 1'b1;
        send(8'hCC, 1'b1);
        vec++;
        if (load !== 1'b1 || d !== W_CC || byte_cnt !== 3'd1) begin
            $display("FAIL flush_same load=%b d=%h cnt=%0d exp 1 %h 1",
                     load, d, byte_cnt, W_CC);
            errs++;
        end
        tick();
        vec++;
        if (load !== 1'b0 || d !== 32'h0) begin
            $display("FAIL flush_same_after load=%b d=%h exp 0 0", load, d);
            errs++;
        end
    endtask

    task automatic test_reset_mid_word();
        out_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        vec++;
        if (d !== W_P3 || byte_cnt !== 3'd3) begin
            $display("FAIL mid_word d=%h cnt=%0d exp %h 3", d, byte_cnt, W_P3);
            errs++;
        end
        #2;
        rst = 1'b0;
        #1;
        vec++;
        if (d !== 32'h0 || byte_cnt !== 3'd0 || load !== 1'b0) begin
            $display("FAIL async_clear d=%h cnt=%0d load=%b exp 0 0 0",
                     d, byte_cnt, load);
            errs++;
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        vec++;
        if (load !== 1'b0 || byte_cnt !== 3'd0) begin
            $display("FAIL post_reset load=%b cnt=%0d exp 0 0", load, byte_cnt);
            errs++;
        end
        send4();
        vec++;
        if (load !== 1'b1 || d !== W_FULL) begin
            $display("FAIL repack load=%b d=%h exp 1 %h", load, d, W_FULL);
            errs++;
        end
        tick();
    endtask

    task automatic test_reset_mid_emit();
        out_ready = 1'b0;
        send4();
        #2;
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        vec++;
        if (load !== 1'b0 || d !== 32'h0 || in_ready !== 1'b1) begin
            $display("FAIL emit_discard load=%b d=%h rdy=%b exp 0 0 1",
                     load, d, in_ready);
            errs++;
        end
    endtask

    task automatic test_single_flush();
        out_ready = 1'b1;
        send(8'hAA, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vec++;
        if (load !== 1'b1 || d !== W_A) begin
            $display("FAIL one_byte_flush load=%b d=%h exp 1 %h", load, d, W_A);
            errs++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            send4();
            vec++;
            if (load !== 1'b1 || d !== W_FULL) begin
                $display("FAIL b2b_%0d load=%b d=%h exp 1 %h",
                         w, load, d, W_FULL);
                errs++;
            end
            in_valid = 1'b1;
            in_byte = 8'h55;
            tick();
            in_valid = 1'b0;
            #1;
            vec++;
            if (load !== 1'b0 || byte_cnt !== 3'd0) begin
                $display("FAIL b2b_gap_%0d load=%b cnt=%0d exp 0 0",
                         w, load, byte_cnt);
                errs++;
            end
        end
    endtask

    initial begin
        vec = 0;
        errs = 0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush();
        test_flush_with_byte();
        test_reset_mid_word();
        test_reset_mid_emit();
        test_single_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
